// File: rtl/lv_wdg_scan_ctrl.sv
// Periodic register-integrity scanner: walks an address window through the arbiter's
// watchdog-scan read port, re-checks each register CRC and flags mismatches/timeouts.
module lv_wdg_scan_ctrl #(
    parameter int unsigned         REG_AW          = 7,
    parameter int unsigned         REG_DW          = 8,
    parameter int unsigned         REG_CRC_W       = 8,
    parameter logic [REG_AW-1:0]   SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0]   SCAN_END_ADDR   = 7'h1F,
    parameter int unsigned         SCAN_PERIOD     = 1000,
    parameter int unsigned         ACK_TO          = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    input  logic                 i_spi_rst_wdg,
    input  logic                 i_err_clr,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
    output logic                 o_crc_err,
    output logic [REG_AW-1:0]    o_err_addr,
    output logic                 o_timeout_err,
    output logic [3:0]           o_crc_err_cnt,
    output logic                 o_scan_done,
    output logic                 o_scan_busy
);

    localparam int unsigned CNT_W = $clog2(SCAN_PERIOD);
    localparam int unsigned TO_W  = $clog2(ACK_TO);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_TERM  = TO_W'(ACK_TO - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_CHK  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              crc_err_q, crc_err_d;
    logic              to_err_q, to_err_d;
    logic              done_q, done_d;
    logic [REG_AW-1:0] err_addr_q, err_addr_d;
    logic [3:0]        err_cnt_q, err_cnt_d;

    // CRC-8, poly 0x07, init 0xFF, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [REG_DW-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = REG_DW - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        crc_err_d  = 1'b0;
        to_err_d   = 1'b0;
        done_d     = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;

        if (crc_err_q && err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
        if (i_err_clr) err_cnt_d = 4'd0;

        // Disable aborts everything, including an ack landing in the same cycle.
        if (!i_scan_en) begin
            state_d = ST_IDLE;
            addr_d  = SCAN_START_ADDR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: begin
                    if (i_spi_rst_wdg) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_TERM) begin
                        state_d = ST_REQ;
                        addr_d  = SCAN_START_ADDR;
                        to_d    = '0;
                        req_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_rac_wdg_scan_ack) begin
                        state_d = ST_CHK;
                        done_d  = (addr_q == SCAN_END_ADDR);
                        if (crc8(i_rac_wdg_scan_data) != i_rac_wdg_scan_crc) begin
                            crc_err_d  = 1'b1;
                            err_addr_d = addr_q;
                        end
                    end else if (to_q == TO_TERM) begin
                        state_d    = ST_CHK;
                        done_d     = (addr_q == SCAN_END_ADDR);
                        to_err_d   = 1'b1;
                        err_addr_d = addr_q;
                    end else begin
                        to_d  = to_q + 1'b1;
                        req_d = 1'b1;
                    end
                end
                ST_CHK: begin
                    if (addr_q == SCAN_END_ADDR) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = addr_q + 1'b1;
                        to_d    = '0;
                        req_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            to_q       <= '0;
            addr_q     <= SCAN_START_ADDR;
            req_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
            done_q     <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            crc_err_q  <= crc_err_d;
            to_err_q   <= to_err_d;
            done_q     <= done_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_wdg_scan_rac_rd_req = req_q;
    assign o_wdg_scan_rac_addr   = addr_q;
    assign o_crc_err             = crc_err_q;
    assign o_timeout_err         = to_err_q;
    assign o_err_addr            = err_addr_q;
    assign o_crc_err_cnt         = err_cnt_q;
    assign o_scan_done           = done_q;
    assign o_scan_busy           = (state_q == ST_REQ) || (state_q == ST_CHK);

endmodule

// File: tb/tb_lv_wdg_scan_ctrl.sv
// Directed bench for lv_wdg_scan_ctrl with a small arbiter responder model.
module tb_lv_wdg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en, spi_rst_wdg, err_clr;
    logic       rd_req;
    logic [6:0] rd_addr;
    logic       ack;
    logic [7:0] rd_data, rd_crc;
    logic       crc_err, timeout_err, scan_done, scan_busy;
    logic [6:0] err_addr;
    logic [3:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Responder controls
    bit force_ack, bad_all, no_ack;
    int bad_a, ack_delay, hold;

    logic [7:0] dat_tbl [4] = '{8'h00, 8'h01, 8'hFF, 8'h00};
    logic [7:0] crc_tbl [4] = '{8'hF3, 8'hF4, 8'h00, 8'hF3};

    lv_wdg_scan_ctrl #(
        .SCAN_PERIOD (10),
        .ACK_TO      (64)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_scan_en             (scan_en),
        .i_spi_rst_wdg         (spi_rst_wdg),
        .i_err_clr             (err_clr),
        .o_wdg_scan_rac_rd_req (rd_req),
        .o_wdg_scan_rac_addr   (rd_addr),
        .i_rac_wdg_scan_ack    (ack),
        .i_rac_wdg_scan_data   (rd_data),
        .i_rac_wdg_scan_crc    (rd_crc),
        .o_crc_err             (crc_err),
        .o_err_addr            (err_addr),
        .o_timeout_err         (timeout_err),
        .o_crc_err_cnt         (err_cnt),
        .o_scan_done           (scan_done),
        .o_scan_busy           (scan_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int bound, output int t);
        bit seen = 1'b0;
        t = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (rd_req) begin
                seen = 1'b1;
                t    = cyc;
                break;
            end
        end
        if (!seen) check("req_wait_expired", 32'd0, 32'd1);
    endtask

    // One full round; expects the request at start of each register, flags in CHK.
    task automatic run_round(input bit all_bad, input int bad_in, output int first_t);
        int  t, prev;
        logic exp_err;
        bad_all = all_bad;
        bad_a   = bad_in;
        first_t = -1;
        prev    = 0;
        for (int a = 0; a < 32; a++) begin
            wait_req(200, t);
            if (a == 0) first_t = t;
            else check("turnaround", t - prev, 3);
            prev = t;
            check("req_addr", {25'd0, rd_addr}, a);
            tick();
            tick();
            exp_err = all_bad || (a == bad_in);
            check("chk_crc_err", crc_err, exp_err);
            check("chk_timeout", timeout_err, 0);
            check("chk_done", scan_done, (a == 31));
            check("chk_busy", scan_busy, 1);
            if (exp_err) check("chk_err_addr", {25'd0, err_addr}, a);
        end
    endtask

    // Arbiter model: acks ack_delay cycles after the request rises.
    initial begin
        ack = 1'b0; rd_data = 8'h00; rd_crc = 8'h00; hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rd_req) hold = 0;
            ack = force_ack || (rd_req && !no_ack && hold == ack_delay);
            if (rd_req) hold++;
            rd_data = dat_tbl[rd_addr[1:0]];
            rd_crc  = crc_tbl[rd_addr[1:0]]
                      ^ ((bad_all || int'(rd_addr) == bad_a) ? 8'h01 : 8'h00);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int e, t, t1, t2, t3, p_last, x;
        rst_n = 1'b0; scan_en = 1'b0; spi_rst_wdg = 1'b0; err_clr = 1'b0;
        force_ack = 1'b0; bad_all = 1'b0; no_ack = 1'b0; bad_a = -1; ack_delay = 1;
        tick(); tick();
        check("rst_req", rd_req, 0);
        check("rst_addr", {25'd0, rd_addr}, 0);
        check("rst_crc_err", crc_err, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_done", scan_done, 0);
        check("rst_busy", scan_busy, 0);
        check("rst_err_addr", {25'd0, err_addr}, 0);
        check("rst_err_cnt", {28'd0, err_cnt}, 0);
        rst_n = 1'b1;
        tick();
        check("idle_req", rd_req, 0);

        // Enable, with spurious acks carrying a bad CRC while IDLE/WAIT
        scan_en = 1'b1; e = cyc; force_ack = 1'b1; bad_all = 1'b1;
        repeat (5) begin
            tick();
            check("spurious_ack", crc_err, 0);
        end
        force_ack = 1'b0; bad_all = 1'b0;
        run_round(1'b0, -1, t1);
        check("first_req_latency", t1 - e, 11);

        run_round(1'b0, 5, t2);
        check("round_period", t2 - t1, 106);
        tick();
        check("cnt_one", {28'd0, err_cnt}, 1);
        check("err_addr_5", {25'd0, err_addr}, 5);

        run_round(1'b1, -1, t3);
        check("round_period2", t3 - t2, 106);
        tick();
        check("cnt_sat", {28'd0, err_cnt}, 15);
        check("err_addr_1f", {25'd0, err_addr}, 31);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("cnt_clr", {28'd0, err_cnt}, 0);

        // Clear coinciding with an increment: clear wins
        wait_req(200, t);
        tick(); tick();
        check("clrwin_pre_err", crc_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clrwin_cnt", {28'd0, err_cnt}, 0);
        check("clrwin_next_addr", {25'd0, rd_addr}, 1);
        tick(); tick(); tick();
        check("cnt_after_clr", {28'd0, err_cnt}, 1);

        // Delayed ack (SPI busy): request held steady for 20 cycles
        bad_all = 1'b0; ack_delay = 20;
        check("delay_start_addr", {25'd0, rd_addr}, 2);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("hold_req", rd_req, 1);
            check("hold_addr", {25'd0, rd_addr}, 2);
        end
        tick();
        check("delay_no_timeout", timeout_err, 0);
        check("delay_no_crc_err", crc_err, 0);

        // No ack: timeout at R+64
        tick();
        check("to_addr", {25'd0, rd_addr}, 3);
        no_ack = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            tick();
            check("to_hold_req", rd_req, 1);
        end
        tick();
        check("to_pulse", timeout_err, 1);
        check("to_err_addr", {25'd0, err_addr}, 3);
        check("to_req_low", rd_req, 0);
        tick();
        check("to_continue_req", rd_req, 1);
        check("to_continue_addr", {25'd0, rd_addr}, 4);

        // Ack on the terminal timeout cycle counts as an ack
        no_ack = 1'b0; ack_delay = 63;
        repeat (63) tick();
        check("term_ack_req", rd_req, 1);
        tick();
        check("term_ack_no_to", timeout_err, 0);
        check("term_ack_chk", rd_req, 0);
        tick();
        ack_delay = 1;
        check("post_term_addr", {25'd0, rd_addr}, 5);

        // Disable in REQ with ack in the same cycle
        tick();
        scan_en = 1'b0;
        tick();
        check("dis_req", rd_req, 0);
        check("dis_crc_err", crc_err, 0);
        check("dis_timeout", timeout_err, 0);
        check("dis_done", scan_done, 0);
        check("dis_busy", scan_busy, 0);
        check("dis_addr", {25'd0, rd_addr}, 0);
        repeat (3) tick();
        scan_en = 1'b1; e = cyc;
        wait_req(30, t);
        check("reen_latency", t - e, 11);
        check("reen_addr", {25'd0, rd_addr}, 0);

        // Watchdog-restart pulses every 5 cycles hold off the round
        scan_en = 1'b0;
        tick(); tick();
        scan_en = 1'b1;
        p_last = 0;
        for (int p = 0; p < 12; p++) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                spi_rst_wdg = (k == 4);
                check("spi_no_req", rd_req, 0);
            end
            p_last = cyc;
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            spi_rst_wdg = 1'b0;
            check("spi_after_no_req", rd_req, 0);
        end
        tick();
        check("spi_req_at_p11", rd_req, 1);
        check("spi_req_delay", cyc - p_last, 11);

        // Asynchronous reset mid-round
        bad_all = 1'b1;
        tick(); tick();
        check("pre_rst_err", crc_err, 1);
        rst_n = 1'b0;
        #1;
        check("arst_req", rd_req, 0);
        check("arst_addr", {25'd0, rd_addr}, 0);
        check("arst_crc_err", crc_err, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_done", scan_done, 0);
        check("arst_busy", scan_busy, 0);
        check("arst_err_addr", {25'd0, err_addr}, 0);
        check("arst_err_cnt", {28'd0, err_cnt}, 0);
        tick(); tick();
        bad_all = 1'b0;
        rst_n = 1'b1; x = cyc;
        wait_req(30, t);
        check("rst_release_latency", t - x, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
